// File: rtl/encoder_16_4_pkg.sv
// ---------------------------------------------------------------------------
// encoder_16_4_pkg
//   Shared types and widths for the sequential 16-to-4 encoder.
//   state_t    : control state of the encoder (IDLE accepts, EMIT streams)
//   IN_W/OUT_W : request vector width and encoded index width
//   clear_sel  : drop the currently selected bit from a pending vector
// ---------------------------------------------------------------------------
package encoder_16_4_pkg;

    localparam int IN_W  = 16;
    localparam int OUT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Remove the bit the priority encoder just picked so the next pass
    // sees only the indices that still have to be emitted.
    function automatic logic [IN_W-1:0] clear_sel(input logic [IN_W-1:0] vec,
                                                  input logic [IN_W-1:0] sel);
        return vec & ~sel;
    endfunction

endpackage

// File: rtl/prio_enc_16_4.sv
// ---------------------------------------------------------------------------
// prio_enc_16_4
//   Purely combinational priority encoder over a 16-bit vector.
//   vec        : candidate bits
//   msb_first  : 0 = lowest set bit wins, 1 = highest set bit wins
//   idx        : binary index of the winning bit (0 when vec is zero)
//   any        : at least one bit of vec is set
//   onehot_sel : one-hot mask of the winning bit (zero when vec is zero)
//   single     : exactly one bit of vec is set
// ---------------------------------------------------------------------------
module prio_enc_16_4
    import encoder_16_4_pkg::*;
(
    input  logic [IN_W-1:0]  vec,
    input  logic             msb_first,
    output logic [OUT_W-1:0] idx,
    output logic             any,
    output logic [IN_W-1:0]  onehot_sel,
    output logic             single
);

    logic [OUT_W-1:0] lo_idx;
    logic [OUT_W-1:0] hi_idx;

    // Both scans run in parallel; the later hit in each loop overrides the
    // earlier one, so scanning downwards leaves the lowest set bit and
    // scanning upwards leaves the highest.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (vec[i]) lo_idx = OUT_W'(i);
        end
        for (int i = 0; i < IN_W; i++) begin
            if (vec[i]) hi_idx = OUT_W'(i);
        end
    end

    always_comb begin
        any        = |vec;
        idx        = msb_first ? hi_idx : lo_idx;
        onehot_sel = any ? (IN_W'(1) << idx) : '0;
        // Clearing the lowest set bit leaves zero only for a power of two.
        single     = any && ((vec & (vec - IN_W'(1))) == '0);
    end

endmodule

// File: rtl/encoder_16_4_seq.sv
// ---------------------------------------------------------------------------
// encoder_16_4_seq
//   Sequential 16-to-4 encoder: accepts a request vector and streams the
//   binary index of every set bit, one beat per index, in priority order.
//
//   Parameters
//     MSB_FIRST : 0 = lowest set bit first, 1 = highest set bit first
//
//   Ports
//     clk, rst_n : clock (rising edge), asynchronous active-low reset
//     in         : request vector, sampled when in_valid && in_ready
//     in_valid   : request vector present
//     in_ready   : encoder idle and able to accept a vector (flop)
//     out        : encoded index of the current beat (flop)
//     out_valid  : out/out_last/out_zero carry a beat (flop)
//     out_ready  : downstream takes the current beat on this edge
//     out_last   : current beat is the final one of the vector (flop)
//     out_zero   : accepted vector was all-zero; out=0 is not a real index
// ---------------------------------------------------------------------------
module encoder_16_4_seq
    import encoder_16_4_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_zero
);

    state_t           state_q,   state_d;
    logic [IN_W-1:0]  pending_q, pending_d;
    logic [OUT_W-1:0] out_d;
    logic             out_valid_d;
    logic             out_last_d;
    logic             out_zero_d;
    logic             in_ready_d;

    // One shared encoder: in IDLE it looks at the incoming vector, in EMIT
    // at the bits still waiting to be emitted.
    logic [IN_W-1:0]  enc_vec;
    logic [OUT_W-1:0] enc_idx;
    logic             enc_any;
    logic [IN_W-1:0]  enc_sel;
    logic             enc_single;

    assign enc_vec = (state_q == IDLE) ? in : pending_q;

    prio_enc_16_4 u_prio (
        .vec        (enc_vec),
        .msb_first  (MSB_FIRST),
        .idx        (enc_idx),
        .any        (enc_any),
        .onehot_sel (enc_sel),
        .single     (enc_single)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        out_d       = out;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        out_zero_d  = out_zero;
        in_ready_d  = in_ready;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                    state_d     = EMIT;
                    if (enc_any) begin
                        pending_d  = clear_sel(in, enc_sel);
                        out_d      = enc_idx;
                        out_last_d = enc_single;
                        out_zero_d = 1'b0;
                    end else begin
                        // An empty vector still yields one beat so the
                        // consumer sees every accepted request complete.
                        pending_d  = '0;
                        out_d      = '0;
                        out_last_d = 1'b1;
                        out_zero_d = 1'b1;
                    end
                end
            end

            EMIT: begin
                // in_valid is deliberately not looked at here; upstream
                // holds its vector until in_ready comes back.
                if (out_ready) begin
                    if (!out_last) begin
                        // out_last=0 guarantees pending still has a bit.
                        pending_d  = clear_sel(pending_q, enc_sel);
                        out_d      = enc_idx;
                        out_last_d = enc_single;
                    end else begin
                        // Final beat taken: drop to IDLE for one bubble
                        // cycle. out keeps its last value, which is
                        // meaningless while out_valid is low.
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_zero_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                pending_d   = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_zero_d  = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_zero  <= out_zero_d;
            in_ready  <= in_ready_d;
        end
    end

endmodule
